// File: rtl/l1_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : l1_bus_arbiter_if
// Description: Bundles the I-cache, D-cache and memory-side bus signals
//              handled by the L1 refill/writeback arbiter.
//              slave  : the arbiter's view (drives responses and commands)
//              master : the environment's view (caches + memory side)
// Revision   : 1.0 - initial release
// ============================================================================
interface l1_bus_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 64
);
    // I-cache side
    logic [ADDR_W-1:0] b_addr_i;
    logic              b_rd_i;
    logic [LINE_W-1:0] b_data_i;
    logic              b_dv_i;
    // D-cache side
    logic [ADDR_W-1:0] b_addr_d;
    logic              b_rd_d;
    logic              b_wr_d;
    logic [LINE_W-1:0] b_wdata_d;
    logic [LINE_W-1:0] b_data_d;
    logic              b_dv_d;
    // memory side
    logic [ADDR_W-1:0] m_addr;
    logic              m_rd;
    logic              m_wr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_dv;
    // status
    logic              busy;

    modport slave (
        input  b_addr_i, b_rd_i,
        input  b_addr_d, b_rd_d, b_wr_d, b_wdata_d,
        input  m_rdata, m_dv,
        output b_data_i, b_dv_i,
        output b_data_d, b_dv_d,
        output m_addr, m_rd, m_wr, m_wdata,
        output busy
    );

    modport master (
        output b_addr_i, b_rd_i,
        output b_addr_d, b_rd_d, b_wr_d, b_wdata_d,
        output m_rdata, m_dv,
        input  b_data_i, b_dv_i,
        input  b_data_d, b_dv_d,
        input  m_addr, m_rd, m_wr, m_wdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/l1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : l1_bus_arbiter
// Description: Round-robin arbiter sharing one L2/memory refill/writeback bus
//              between the L1 instruction and data caches of a hart. The
//              winning request's address, command and write line are
//              registered at grant; the memory completion pulse is routed back
//              to the owning cache only.
// Revision   : 1.0 - initial release
// ============================================================================
module l1_bus_arbiter #(
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 64,
    parameter int OFFS_LEN = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    l1_bus_arbiter_if.slave   bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_gnt_i = 2'd1;
    localparam logic [1:0] c_gnt_d = 2'd2;
    localparam logic [1:0] c_rel   = 2'd3;

    // Clears the line-offset bits so memory always sees a line-aligned address.
    localparam logic [ADDR_W-1:0] c_line_mask =
        {{(ADDR_W-OFFS_LEN){1'b1}}, {OFFS_LEN{1'b0}}};

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_last_d;     // 1: D-cache was granted last
    logic [ADDR_W-1:0] r_m_addr;
    logic              r_m_rd;
    logic              r_m_wr;
    logic [LINE_W-1:0] r_m_wdata;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_done;

    // ------------------------------------------------------------------
    // Request decode and round-robin grant selection
    // ------------------------------------------------------------------
    assign w_req_i = bus.b_rd_i;
    assign w_req_d = bus.b_rd_d | bus.b_wr_d;

    // On a tie the side that was not served last wins.
    assign w_grant_i = (r_state == c_idle) && w_req_i && (!w_req_d || r_last_d);
    assign w_grant_d = (r_state == c_idle) && w_req_d && (!w_req_i || !r_last_d);

    // Memory completion only counts while a grant is active.
    assign w_done = bus.m_dv && ((r_state == c_gnt_i) || (r_state == c_gnt_d));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_grant_i) begin
                    w_next = c_gnt_i;
                end else if (w_grant_d) begin
                    w_next = c_gnt_d;
                end
            end
            c_gnt_i,
            c_gnt_d: begin
                if (bus.m_dv) begin
                    w_next = c_rel;
                end
            end
            // Dead cycle so the requester can drop its level request.
            c_rel:   w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: completion routing and busy, forced low in reset
    // ------------------------------------------------------------------
    always_comb begin
        bus.b_dv_i   = 1'b0;
        bus.b_dv_d   = 1'b0;
        bus.busy     = 1'b0;
        bus.b_data_i = '0;
        bus.b_data_d = '0;
        if (rst_n) begin
            bus.b_dv_i   = bus.m_dv && (r_state == c_gnt_i);
            bus.b_dv_d   = bus.m_dv && (r_state == c_gnt_d);
            bus.busy     = (r_state == c_gnt_i) || (r_state == c_gnt_d);
            // Read data is shared; only the side receiving dv consumes it.
            bus.b_data_i = bus.m_rdata;
            bus.b_data_d = bus.m_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Command capture at grant, release on completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_d  <= 1'b1;
            r_m_addr  <= '0;
            r_m_rd    <= 1'b0;
            r_m_wr    <= 1'b0;
            r_m_wdata <= '0;
        end else if (w_grant_i) begin
            r_last_d  <= 1'b0;
            r_m_addr  <= bus.b_addr_i & c_line_mask;
            r_m_rd    <= 1'b1;
            r_m_wr    <= 1'b0;
        end else if (w_grant_d) begin
            // A simultaneous read and writeback resolves to the writeback.
            r_last_d  <= 1'b1;
            r_m_addr  <= bus.b_addr_d & c_line_mask;
            r_m_rd    <= bus.b_rd_d & ~bus.b_wr_d;
            r_m_wr    <= bus.b_wr_d;
            r_m_wdata <= bus.b_wdata_d;
        end else if (w_done) begin
            r_m_rd    <= 1'b0;
            r_m_wr    <= 1'b0;
        end
    end

    assign bus.m_addr  = r_m_addr;
    assign bus.m_rd    = r_m_rd;
    assign bus.m_wr    = r_m_wr;
    assign bus.m_wdata = r_m_wdata;

endmodule
`default_nettype wire
